// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// unified_mem_arbiter: sequences data access then instruction fetch onto one
// single-port memory, stalling the pipeline and buffering both read results.
// Revision: 1.0
// ----------------------------------------------------------------------------
module unified_mem_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      inst_ad,
    input  logic [31:0]      mem_ad,
    input  logic [31:0]      mem_write_data,
    input  logic             datamem_mem_read,
    input  logic             datamem_mem_write,
    output logic [31:0]      inst,
    output logic [31:0]      readdata,
    output logic             mem_stall,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_ready,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        PH_D = 2'd0,
        PH_I = 2'd1,
        REL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state_q, state_d;
    logic [31:0]       inst_q, inst_d;
    logic [31:0]       readdata_q, readdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              dop;

    always_comb begin
        dop        = datamem_mem_read | datamem_mem_write;
        state_d    = state_q;
        inst_d     = inst_q;
        readdata_d = readdata_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = 32'h0;
        mem_wdata  = 32'h0;
        mem_stall  = 1'b1;

        case (state_q)
            PH_D: begin
                mem_req = 1'b1;
                if (dop) begin
                    // Read+write together is treated as a store: no load capture.
                    mem_we    = datamem_mem_write;
                    mem_addr  = mem_ad;
                    mem_wdata = mem_write_data;
                    if (mem_ready) begin
                        if (!datamem_mem_write) readdata_d = mem_rdata;
                        state_d = PH_I;
                    end
                end else begin
                    mem_addr = inst_ad;
                    if (mem_ready) begin
                        inst_d  = mem_rdata;
                        state_d = REL;
                    end
                end
            end
            PH_I: begin
                mem_req  = 1'b1;
                mem_addr = inst_ad;
                if (mem_ready) begin
                    inst_d  = mem_rdata;
                    state_d = REL;
                end
            end
            REL: begin
                mem_stall = 1'b0;
                state_d   = PH_D;
            end
            default: state_d = PH_D;
        endcase

        if (rst) begin
            mem_req   = 1'b0;
            mem_stall = 1'b1;
        end

        cnt_d = (mem_stall && (cnt_q != CNT_MAX)) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= PH_D;
            inst_q     <= 32'h0;
            readdata_q <= 32'h0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            inst_q     <= inst_d;
            readdata_q <= readdata_d;
            cnt_q      <= cnt_d;
        end
    end

    assign inst      = inst_q;
    assign readdata  = readdata_q;
    assign stall_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_unified_mem_arbiter: directed self-checking bench with a small
// wait-state memory responder.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_unified_mem_arbiter;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [31:0]      inst_ad, mem_ad, mem_write_data;
    logic             datamem_mem_read, datamem_mem_write;
    logic [31:0]      inst, readdata, mem_addr, mem_wdata, mem_rdata;
    logic             mem_stall, mem_req, mem_we, mem_ready;
    logic [CNT_W-1:0] stall_cnt;

    logic             never_ready;
    int unsigned      req_age;
    int               n_checks;
    int               n_pass;

    always #5 clk = ~clk;

    unified_mem_arbiter #(.CNT_W(CNT_W)) u_dut (
        .clk               (clk),
        .rst               (rst),
        .inst_ad           (inst_ad),
        .mem_ad            (mem_ad),
        .mem_write_data    (mem_write_data),
        .datamem_mem_read  (datamem_mem_read),
        .datamem_mem_write (datamem_mem_write),
        .inst              (inst),
        .readdata          (readdata),
        .mem_stall         (mem_stall),
        .mem_req           (mem_req),
        .mem_we            (mem_we),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_rdata         (mem_rdata),
        .mem_ready         (mem_ready),
        .stall_cnt         (stall_cnt)
    );

    function automatic logic [31:0] mem_lookup(input logic [31:0] a);
        case (a)
            32'h0000_0000: mem_lookup = 32'h2008_0005;
            32'h0000_0004: mem_lookup = 32'h0000_0013;
            32'h0000_0008: mem_lookup = 32'hAAAA_5555;
            32'h0000_0020: mem_lookup = 32'hCAFE_F00D;
            32'h0000_0040: mem_lookup = 32'hDEAD_BEEF;
            32'h0000_0100: mem_lookup = 32'h8C09_0040;
            default:       mem_lookup = 32'h0BAD_0BAD;
        endcase
    endfunction

    function automatic int unsigned wait_for(input logic [31:0] a);
        case (a)
            32'h0000_0040: wait_for = 2;
            32'h0000_0044: wait_for = 3;
            default:       wait_for = 0;
        endcase
    endfunction

    assign mem_rdata = mem_lookup(mem_addr);
    assign mem_ready = !never_ready && mem_req && (req_age >= wait_for(mem_addr));

    always @(posedge clk) begin
        if (!mem_req || mem_ready) req_age <= 0;
        else                       req_age <= req_age + 1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    endtask

    // Advance to the next cycle: inputs change at negedge, outputs sampled 1ns later.
    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic set_op(input logic rd, input logic wr, input logic [31:0] dad,
                          input logic [31:0] wd, input logic [31:0] iad);
        datamem_mem_read  = rd;
        datamem_mem_write = wr;
        mem_ad            = dad;
        mem_write_data    = wd;
        inst_ad           = iad;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        never_ready = 1'b0;
        req_age  = 0;
        rst = 1'b1;
        set_op(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);

        // Reset behaviour
        next_cycle();
        next_cycle();
        check("rst_req",   {31'h0, mem_req},   32'h0);
        check("rst_stall", {31'h0, mem_stall}, 32'h1);

        // Fetch only, zero-wait: PH_D-fetch then REL
        @(negedge clk); rst = 1'b0; #1;
        check("rst_inst",  inst,                  32'h0);
        check("rst_rdata", readdata,              32'h0);
        check("rst_cnt",   {28'h0, stall_cnt},    32'h0);
        check("f_req",     {31'h0, mem_req},      32'h1);
        check("f_we",      {31'h0, mem_we},       32'h0);
        check("f_addr",    mem_addr,              32'h0);
        check("f_stall",   {31'h0, mem_stall},    32'h1);
        next_cycle();
        check("f_rel_stall", {31'h0, mem_stall},  32'h0);
        check("f_rel_req",   {31'h0, mem_req},    32'h0);
        check("f_rel_inst",  inst,                32'h2008_0005);
        check("f_rel_cnt",   {28'h0, stall_cnt},  32'h1);

        // Load with 2 wait states, then zero-wait fetch
        @(negedge clk);
        set_op(1'b1, 1'b0, 32'h40, 32'h0, 32'h100);
        #1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) next_cycle();
            check("ld_addr",  mem_addr,           32'h40);
            check("ld_stall", {31'h0, mem_stall}, 32'h1);
        end
        next_cycle();
        check("ld_if_addr", mem_addr,           32'h100);
        check("ld_if_we",   {31'h0, mem_we},    32'h0);
        check("ld_rdata",   readdata,           32'hDEAD_BEEF);
        next_cycle();
        check("ld_rel_stall", {31'h0, mem_stall}, 32'h0);
        check("ld_inst",      inst,               32'h8C09_0040);
        check("ld_cnt",       {28'h0, stall_cnt}, 32'h5);

        // Store then fetch
        @(negedge clk);
        set_op(1'b0, 1'b1, 32'h10, 32'h1234_5678, 32'h4);
        #1;
        check("st_req",   {31'h0, mem_req}, 32'h1);
        check("st_we",    {31'h0, mem_we},  32'h1);
        check("st_addr",  mem_addr,         32'h10);
        check("st_wdata", mem_wdata,        32'h1234_5678);
        next_cycle();
        check("st_if_we",    {31'h0, mem_we}, 32'h0);
        check("st_if_addr",  mem_addr,        32'h4);
        check("st_if_wdata", mem_wdata,       32'h0);
        next_cycle();
        check("st_rdata", readdata,           32'hDEAD_BEEF);
        check("st_inst",  inst,               32'h0000_0013);
        check("st_cnt",   {28'h0, stall_cnt}, 32'h7);

        // Read and write both set: issued as a write, no load capture
        @(negedge clk);
        set_op(1'b1, 1'b1, 32'h20, 32'h5555_AAAA, 32'h8);
        #1;
        check("rw_we",   {31'h0, mem_we}, 32'h1);
        check("rw_addr", mem_addr,        32'h20);
        next_cycle();
        check("rw_if_addr", mem_addr, 32'h8);
        check("rw_rdata",   readdata,  32'hDEAD_BEEF);
        next_cycle();
        check("rw_rel_rdata", readdata,           32'hDEAD_BEEF);
        check("rw_inst",      inst,               32'hAAAA_5555);
        check("rw_cnt",       {28'h0, stall_cnt}, 32'h9);

        // Reset during the PH_I wait
        @(negedge clk);
        set_op(1'b1, 1'b0, 32'h20, 32'h0, 32'h44);
        #1;
        next_cycle();
        check("rp_if_addr", mem_addr,         32'h44);
        check("rp_if_req",  {31'h0, mem_req}, 32'h1);
        check("rp_rdata",   readdata,         32'hCAFE_F00D);
        @(negedge clk); rst = 1'b1; #1;
        check("rp_rst_req", {31'h0, mem_req}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        set_op(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        #1;
        check("rp_inst",  inst,               32'h0);
        check("rp_rdata0", readdata,          32'h0);
        check("rp_cnt",   {28'h0, stall_cnt}, 32'h0);
        check("rp_phd_addr", mem_addr,        32'h0);
        next_cycle();
        check("rp_rel_stall", {31'h0, mem_stall}, 32'h0);
        check("rp_rel_inst",  inst,               32'h2008_0005);

        // Memory never ready: counter saturates at 15, request held stable
        @(negedge clk); rst = 1'b1; never_ready = 1'b1; #1;
        @(negedge clk);
        rst = 1'b0;
        set_op(1'b0, 1'b0, 32'h0, 32'h0, 32'h100);
        #1;
        for (int i = 0; i <= 20; i++) begin
            if (i > 0) next_cycle();
            check("sat_cnt",  {28'h0, stall_cnt}, (i < 15) ? i : 15);
            check("sat_req",  {31'h0, mem_req},   32'h1);
            check("sat_addr", mem_addr,           32'h100);
        end
        never_ready = 1'b0;
        next_cycle();
        check("sat_rel_inst", inst,               32'h8C09_0040);
        check("sat_rel_cnt",  {28'h0, stall_cnt}, 32'hF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
